// File: rtl/io_timer_pkg.sv
// io_timer_pkg: shared register map, CTRL bit layout and control struct
// for the io_timer_array peripheral and its channel sub-module.
package io_timer_pkg;

   // Per-channel register offsets (low nibble of the channel slot)
   localparam logic [3:0] REG_CTRL    = 4'h0;
   localparam logic [3:0] REG_COUNT   = 4'h4;
   localparam logic [3:0] REG_COMPARE = 4'h8;
   localparam logic [3:0] REG_STATUS  = 4'hC;

   // Shared prescaler register, offset within the 512 B window
   localparam logic [8:0] REG_PRESCALE = 9'h100;

   // Byte distance between consecutive channel register slots
   localparam int unsigned CHAN_STRIDE = 16;

   // CTRL bit indices
   localparam int unsigned CTRL_EN_BIT          = 0;
   localparam int unsigned CTRL_AUTO_RELOAD_BIT = 1;
   localparam int unsigned CTRL_IRQ_EN_BIT      = 2;

   // CTRL register image; en lands in bit 0 when zero-extended
   typedef struct packed {
      logic irq_en;
      logic auto_reload;
      logic en;
   } io_timer_ctrl_t;

endpackage

// File: rtl/io_timer_array_if.sv
// io_timer_array_if: I/O bus slave port of the timer array.
//   io_bus_s_rd_en    read strobe, one cycle per access
//   io_bus_s_wr_en    write strobe, one cycle per access
//   io_bus_s_address  byte address
//   io_bus_s_wr_data  write data
//   rd_data           registered read data returned by the slave
interface io_timer_array_if;

   logic        io_bus_s_rd_en;
   logic        io_bus_s_wr_en;
   logic [31:0] io_bus_s_address;
   logic [31:0] io_bus_s_wr_data;
   logic [31:0] rd_data;

   modport master (
      output io_bus_s_rd_en, io_bus_s_wr_en, io_bus_s_address, io_bus_s_wr_data,
      input  rd_data
   );

   modport slave (
      input  io_bus_s_rd_en, io_bus_s_wr_en, io_bus_s_address, io_bus_s_wr_data,
      output rd_data
   );

endinterface

// File: rtl/io_timer_channel.sv
// io_timer_channel: one compare channel (CTRL/COUNT/COMPARE/PENDING),
// match / reload / one-shot logic and the registered interrupt.
//   clk, rst        clock, synchronous active-high reset
//   tick            prescaled count enable shared by all channels
//   wr_ctrl..       decoded single-register write strobes
//   wr_data         write data truncated to the counter width
//   ctrl, count,
//   compare,pending register contents for the read mux
//   irq             PENDING & IRQ_EN, registered
module io_timer_channel
   import io_timer_pkg::*;
#(
   parameter int unsigned COUNTER_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     tick,
   input  logic                     wr_ctrl,
   input  logic                     wr_count,
   input  logic                     wr_compare,
   input  logic                     wr_status,
   input  logic [COUNTER_WIDTH-1:0] wr_data,
   output io_timer_ctrl_t           ctrl,
   output logic [COUNTER_WIDTH-1:0] count,
   output logic [COUNTER_WIDTH-1:0] compare,
   output logic                     pending,
   output logic                     irq
);

   io_timer_ctrl_t           ctrl_q, ctrl_d;
   logic [COUNTER_WIDTH-1:0] count_q, count_d;
   logic [COUNTER_WIDTH-1:0] compare_q, compare_d;
   logic                     pending_q, pending_d;
   logic                     irq_q, irq_d;
   logic                     match_set;

   // Tick update first, then software writes override it
   always_comb begin
      ctrl_d    = ctrl_q;
      count_d   = count_q;
      compare_d = compare_q;
      pending_d = pending_q;
      match_set = 1'b0;

      // A software write to CTRL or COUNT discards this tick's update
      if (tick && ctrl_q.en && !wr_ctrl && !wr_count) begin
         if (count_q == compare_q) begin
            match_set = 1'b1;
            if (ctrl_q.auto_reload) begin
               count_d = '0;
            end else begin
               ctrl_d.en = 1'b0;
            end
         end else begin
            count_d = count_q + COUNTER_WIDTH'(1);
         end
      end

      if (wr_ctrl) begin
         ctrl_d.en          = wr_data[CTRL_EN_BIT];
         ctrl_d.auto_reload = wr_data[CTRL_AUTO_RELOAD_BIT];
         ctrl_d.irq_en      = wr_data[CTRL_IRQ_EN_BIT];
      end
      if (wr_count) begin
         count_d = wr_data;
      end
      if (wr_compare) begin
         compare_d = wr_data;
      end

      // Clear then set, so a coincident match keeps PENDING high
      if (wr_status && wr_data[0]) begin
         pending_d = 1'b0;
      end
      if (match_set) begin
         pending_d = 1'b1;
      end

      irq_d = pending_d & ctrl_d.irq_en;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q    <= '0;
         count_q   <= '0;
         compare_q <= '1;
         pending_q <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         ctrl_q    <= ctrl_d;
         count_q   <= count_d;
         compare_q <= compare_d;
         pending_q <= pending_d;
         irq_q     <= irq_d;
      end
   end

   assign ctrl    = ctrl_q;
   assign count   = count_q;
   assign compare = compare_q;
   assign pending = pending_q;
   assign irq     = irq_q;

endmodule

// File: rtl/io_timer_array.sv
// io_timer_array: NUM_CHANNELS compare timers on the I/O bus with a shared
// prescaler, own address-window decode and a registered read mux.
//   clk, rst  clock, synchronous active-high reset
//   bus       io_timer_array_if slave port (strobes, address, data, rd_data)
//   irq       per-channel level interrupt
// Optional feature macro: IO_TIMER_PRESCALER_EN (prescaler + PRESCALE
// register); when undefined the timers tick every cycle and 0x100 reads 0.
module io_timer_array
   import io_timer_pkg::*;
#(
   parameter int unsigned NUM_CHANNELS    = 4,
   parameter int unsigned COUNTER_WIDTH   = 32,
   parameter int unsigned PRESCALER_WIDTH = 16,
   parameter logic [31:0] BASE_ADDRESS    = 32'h0
) (
   input  logic                    clk,
   input  logic                    rst,
   io_timer_array_if.slave         bus,
   output logic [NUM_CHANNELS-1:0] irq
);

   logic [8:0]  offset;
   logic [3:0]  chan_idx;
   logic [3:0]  reg_sel;
   logic        hit;
   logic        chan_valid;
   logic        wr;
   logic        tick_raw;
   logic        tick;
   logic [31:0] prescale_rd;
   logic [31:0] chan_rd;
   logic [31:0] rd_sel;
   logic [31:0] rd_data_q, rd_data_d;
   logic        tick_block_q, tick_block_d;
   logic        unused_wr_data;

   io_timer_ctrl_t           ctrl_a    [NUM_CHANNELS];
   logic [COUNTER_WIDTH-1:0] count_a   [NUM_CHANNELS];
   logic [COUNTER_WIDTH-1:0] compare_a [NUM_CHANNELS];
   logic                     pending_a [NUM_CHANNELS];

   // Window decode: channel slots below 0x100, PRESCALE at 0x100
   assign offset     = bus.io_bus_s_address[8:0];
   assign hit        = (bus.io_bus_s_address[31:9] == BASE_ADDRESS[31:9]);
   assign chan_idx   = 4'(offset[7:0] / 8'(CHAN_STRIDE));
   assign reg_sel    = offset[3:0];
   assign chan_valid = hit && !offset[8] && (32'(chan_idx) < NUM_CHANNELS);
   assign wr         = bus.io_bus_s_wr_en;

   // Bits above the register widths are dropped on write
   assign unused_wr_data = ^bus.io_bus_s_wr_data;

`ifdef IO_TIMER_PRESCALER_EN
   logic [PRESCALER_WIDTH-1:0] prescale_q, prescale_d;
   logic [PRESCALER_WIDTH-1:0] pcnt_q, pcnt_d;
   logic                       wr_prescale;

   assign wr_prescale = wr && hit && (offset == REG_PRESCALE);
   assign tick_raw    = (pcnt_q == prescale_q);
   assign prescale_rd = 32'(prescale_q);

   // pcnt runs 0..PRESCALE; a PRESCALE write restarts the period
   always_comb begin
      prescale_d = prescale_q;
      pcnt_d     = tick_raw ? '0 : pcnt_q + PRESCALER_WIDTH'(1);
      if (wr_prescale) begin
         prescale_d = bus.io_bus_s_wr_data[PRESCALER_WIDTH-1:0];
         pcnt_d     = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prescale_q <= '0;
         pcnt_q     <= '0;
      end else begin
         prescale_q <= prescale_d;
         pcnt_q     <= pcnt_d;
      end
   end
`else
   // No prescaler: every cycle is a tick and the PRESCALE slot reads zero
   assign tick_raw    = 1'b1;
   assign prescale_rd = 32'({PRESCALER_WIDTH{1'b0}});
`endif

   // No tick in the first cycle after reset
   assign tick = tick_raw & ~tick_block_q;

   for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
      logic wr_sel;
      assign wr_sel = wr && chan_valid && (chan_idx == 4'(i));

      io_timer_channel #(
         .COUNTER_WIDTH (COUNTER_WIDTH)
      ) u_chan (
         .clk        (clk),
         .rst        (rst),
         .tick       (tick),
         .wr_ctrl    (wr_sel && (reg_sel == REG_CTRL)),
         .wr_count   (wr_sel && (reg_sel == REG_COUNT)),
         .wr_compare (wr_sel && (reg_sel == REG_COMPARE)),
         .wr_status  (wr_sel && (reg_sel == REG_STATUS)),
         .wr_data    (bus.io_bus_s_wr_data[COUNTER_WIDTH-1:0]),
         .ctrl       (ctrl_a[i]),
         .count      (count_a[i]),
         .compare    (compare_a[i]),
         .pending    (pending_a[i]),
         .irq        (irq[i])
      );
   end

   // Read mux samples pre-write register values; rd_data holds between reads
   always_comb begin
      chan_rd      = '0;
      rd_sel       = '0;
      tick_block_d = 1'b0;

      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (chan_idx == 4'(i)) begin
            case (reg_sel)
               REG_CTRL:    chan_rd = 32'(ctrl_a[i]);
               REG_COUNT:   chan_rd = 32'(count_a[i]);
               REG_COMPARE: chan_rd = 32'(compare_a[i]);
               REG_STATUS:  chan_rd = 32'(pending_a[i]);
               default:     chan_rd = '0;
            endcase
         end
      end

      if (hit && (offset == REG_PRESCALE)) begin
         rd_sel = prescale_rd;
      end else if (chan_valid) begin
         rd_sel = chan_rd;
      end

      rd_data_d = bus.io_bus_s_rd_en ? rd_sel : rd_data_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q    <= '0;
         tick_block_q <= 1'b1;
      end else begin
         rd_data_q    <= rd_data_d;
         tick_block_q <= tick_block_d;
      end
   end

   assign bus.rd_data = rd_data_q;

endmodule

// File: tb/tb_io_timer_array.sv
// tb_io_timer_array: directed test-plan sequences followed by randomized
// bus traffic, checked every cycle against a behavioural register model.
module tb_io_timer_array;

   localparam int unsigned NCH  = 4;
   localparam int unsigned CW   = 32;
   localparam int unsigned PW   = 16;
   localparam logic [31:0] BASE = 32'h0000_1200;
   localparam logic [31:0] CMASK = (CW >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << CW) - 64'd1);
   localparam logic [31:0] PMASK = (PW >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << PW) - 64'd1);
   localparam logic [31:0] PS_ADDR  = BASE + 32'h100;
   localparam logic [31:0] OUT_BASE = BASE ^ 32'h0000_0200;
`ifdef IO_TIMER_PRESCALER_EN
   localparam int PERIOD = 12;
`else
   localparam int PERIOD = 3;
`endif

   logic           clk = 1'b0;
   logic           rst;
   logic [NCH-1:0] irq;

   io_timer_array_if bus_if ();

   io_timer_array #(
      .NUM_CHANNELS    (NCH),
      .COUNTER_WIDTH   (CW),
      .PRESCALER_WIDTH (PW),
      .BASE_ADDRESS    (BASE)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if),
      .irq (irq)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [2:0]     m_ctrl  [NCH];
   logic [31:0]    m_count [NCH];
   logic [31:0]    m_cmp   [NCH];
   logic           m_pend  [NCH];
   logic [31:0]    m_pre;
   logic [31:0]    m_pcnt;
   logic [31:0]    m_rd;
   logic [NCH-1:0] m_irq;
   logic           m_sup;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] ca(input int ch, input int rg);
      return BASE + 32'(ch * 16) + 32'(rg);
   endfunction

   function automatic logic [31:0] mread(input logic [31:0] a);
      int ch;
      if (a[31:9] != BASE[31:9]) return 32'h0;
      if (a[8:0] == 9'h100) begin
`ifdef IO_TIMER_PRESCALER_EN
         return m_pre;
`else
         return 32'h0;
`endif
      end
      if (a[8]) return 32'h0;
      ch = int'(a[7:4]);
      if (ch >= NCH) return 32'h0;
      case (a[3:0])
         4'h0:    return {29'h0, m_ctrl[ch]};
         4'h4:    return m_count[ch];
         4'h8:    return m_cmp[ch];
         4'hC:    return {31'h0, m_pend[ch]};
         default: return 32'h0;
      endcase
   endfunction

   // Advance the model by one clock using the inputs presented this cycle
   task automatic model_step(input logic r, input logic rd, input logic wr,
                             input logic [31:0] a, input logic [31:0] wd);
      logic tick, in_win, sw_hit, set;
      int   ch;
      logic [3:0] rg;
      if (r) begin
         for (int i = 0; i < NCH; i++) begin
            m_ctrl[i] = 3'b0; m_count[i] = 32'h0; m_cmp[i] = CMASK; m_pend[i] = 1'b0;
         end
         m_pre = 32'h0; m_pcnt = 32'h0; m_rd = 32'h0; m_irq = '0; m_sup = 1'b1;
         return;
      end
      if (rd) m_rd = mread(a);
`ifdef IO_TIMER_PRESCALER_EN
      tick = (m_pcnt == m_pre);
`else
      tick = 1'b1;
`endif
      if (m_sup) tick = 1'b0;
      m_sup  = 1'b0;
      in_win = (a[31:9] == BASE[31:9]);
      ch     = int'(a[7:4]);
      rg     = a[3:0];
      for (int i = 0; i < NCH; i++) begin
         sw_hit = wr && in_win && !a[8] && (ch == i);
         set    = 1'b0;
         if (tick && m_ctrl[i][0] && !(sw_hit && (rg == 4'h0 || rg == 4'h4))) begin
            if (m_count[i] == m_cmp[i]) begin
               set = 1'b1;
               if (m_ctrl[i][1]) m_count[i] = 32'h0;
               else              m_ctrl[i][0] = 1'b0;
            end else begin
               m_count[i] = (m_count[i] + 32'd1) & CMASK;
            end
         end
         if (sw_hit) begin
            case (rg)
               4'h0: m_ctrl[i]  = wd[2:0];
               4'h4: m_count[i] = wd & CMASK;
               4'h8: m_cmp[i]   = wd & CMASK;
               4'hC: if (wd[0]) m_pend[i] = 1'b0;
               default: ;
            endcase
         end
         if (set) m_pend[i] = 1'b1;
         m_irq[i] = m_pend[i] & m_ctrl[i][2];
      end
`ifdef IO_TIMER_PRESCALER_EN
      if (wr && in_win && a[8:0] == 9'h100) begin
         m_pre  = wd & PMASK;
         m_pcnt = 32'h0;
      end else if (m_pcnt == m_pre) begin
         m_pcnt = 32'h0;
      end else begin
         m_pcnt = m_pcnt + 32'd1;
      end
`endif
   endtask

   task automatic cycle();
      model_step(rst, bus_if.io_bus_s_rd_en, bus_if.io_bus_s_wr_en,
                 bus_if.io_bus_s_address, bus_if.io_bus_s_wr_data);
      @(posedge clk);
      #1;
      chk("irq", 32'(irq), 32'(m_irq));
      chk("rd_data", bus_if.rd_data, m_rd);
      bus_if.io_bus_s_rd_en = 1'b0;
      bus_if.io_bus_s_wr_en = 1'b0;
   endtask

   task automatic do_wr(input logic [31:0] a, input logic [31:0] d);
      bus_if.io_bus_s_wr_en    = 1'b1;
      bus_if.io_bus_s_address  = a;
      bus_if.io_bus_s_wr_data  = d;
      cycle();
   endtask

   task automatic do_rd(input logic [31:0] a, output logic [31:0] d);
      bus_if.io_bus_s_rd_en   = 1'b1;
      bus_if.io_bus_s_address = a;
      cycle();
      d = bus_if.rd_data;
   endtask

   task automatic do_rst();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      int          n;

      rst = 1'b1;
      bus_if.io_bus_s_rd_en    = 1'b0;
      bus_if.io_bus_s_wr_en    = 1'b0;
      bus_if.io_bus_s_address  = 32'h0;
      bus_if.io_bus_s_wr_data  = 32'h0;
      cycle();
      do_rst();

      // Reset values
      chk("rst_irq", 32'(irq), 32'h0);
      chk("rst_rd_data", bus_if.rd_data, 32'h0);
      do_rd(ca(0, 4'h0), d); chk("rst_ctrl", d, 32'h0);
      do_rd(ca(0, 4'h4), d); chk("rst_count", d, 32'h0);
      do_rd(ca(0, 4'h8), d); chk("rst_compare", d, 32'hFFFF_FFFF);
      do_rd(ca(0, 4'hC), d); chk("rst_status", d, 32'h0);
      do_rd(PS_ADDR, d);     chk("rst_prescale", d, 32'h0);

      // Channel 0 auto-reload with interrupt
      do_wr(ca(0, 4'h8), 32'd5);
      do_wr(ca(0, 4'h0), 32'b111);
      n = 0;
      while (irq[0] == 1'b0 && n < 100) begin cycle(); n++; end
      chk("ch0_irq_latency", 32'(n), 32'd6);
      do_rd(ca(0, 4'h4), d); chk("ch0_reload", d, 32'h0);
      do_wr(ca(0, 4'hC), 32'h1);
      chk("ch0_w1c_irq", 32'(irq[0]), 32'h0);
      do_wr(ca(0, 4'h0), 32'h0);
      do_wr(ca(0, 4'hC), 32'h1);

      // Channel 1 one-shot
      do_wr(ca(1, 4'h8), 32'd3);
      do_wr(ca(1, 4'h0), 32'b101);
      repeat (10) cycle();
      do_rd(ca(1, 4'hC), d); chk("ch1_pending", d, 32'h1);
      do_rd(ca(1, 4'h0), d); chk("ch1_en_cleared", d, 32'h4);
      do_rd(ca(1, 4'h4), d); chk("ch1_count_hold", d, 32'h3);
      do_wr(ca(1, 4'hC), 32'h1);
      repeat (10) cycle();
      chk("ch1_no_reirq", 32'(irq[1]), 32'h0);

      // Prescaled auto-reload period on channel 2
      do_wr(PS_ADDR, 32'd3);
      do_wr(ca(2, 4'h8), 32'd2);
      do_wr(ca(2, 4'h0), 32'b111);
      n = 0;
      while (irq[2] == 1'b0 && n < 100) begin cycle(); n++; end
      chk("ch2_first_irq", 32'(irq[2]), 32'h1);
      do_wr(ca(2, 4'hC), 32'h1);
      n = 1;
      while (irq[2] == 1'b0 && n < 100) begin cycle(); n++; end
      chk("ch2_period", 32'(n), 32'(PERIOD));
      do_wr(ca(2, 4'h0), 32'h0);
      do_wr(ca(2, 4'hC), 32'h1);
      do_wr(PS_ADDR, 32'h0);

      // W1C coinciding with a match keeps PENDING set
      do_rst();
      do_wr(ca(0, 4'h8), 32'd5);
      do_wr(ca(0, 4'h0), 32'b111);
      repeat (5) cycle();
      do_wr(ca(0, 4'hC), 32'h1);
      do_rd(ca(0, 4'hC), d); chk("w1c_vs_match", d, 32'h1);

      // COUNT write on a tick cycle wins
      do_wr(ca(0, 4'h4), 32'h77);
      do_rd(ca(0, 4'h4), d); chk("count_wr_on_tick", d, 32'h77);

      // Out-of-range and out-of-window accesses
      do_rd(ca(NCH, 4'h8), d);     chk("rd_chan_oor", d, 32'h0);
      do_rd(OUT_BASE + 32'h8, d);  chk("rd_out_window", d, 32'h0);
      do_rd(BASE + 32'h104, d);    chk("rd_unmapped", d, 32'h0);
      do_wr(ca(NCH, 4'h8), 32'hAB);
      do_wr(OUT_BASE + 32'h8, 32'hAB);
      do_rd(ca(0, 4'h8), d);       chk("wr_ignored", d, 32'd5);

      // Reset mid-count
      do_rst();
      chk("midrst_irq", 32'(irq), 32'h0);
      chk("midrst_rd_data", bus_if.rd_data, 32'h0);
      do_rd(ca(0, 4'h4), d); chk("midrst_count", d, 32'h0);
      do_rd(ca(0, 4'h0), d); chk("midrst_ctrl", d, 32'h0);
      do_rd(ca(0, 4'h8), d); chk("midrst_compare", d, 32'hFFFF_FFFF);

      // Randomized traffic against the model
      for (int k = 0; k < 3000; k++) begin
         int unsigned r, asel, dsel;
         logic [31:0] a, wd;
         r    = $urandom_range(0, 99);
         asel = $urandom_range(0, 19);
         dsel = $urandom_range(0, 9);
         if (asel < 16)       a = ca(int'($urandom_range(0, NCH)), int'(4 * $urandom_range(0, 3)));
         else if (asel < 18)  a = PS_ADDR;
         else if (asel == 18) a = BASE + 32'h104;
         else                 a = OUT_BASE + 32'(4 * $urandom_range(0, 3));
         if (dsel < 6)       wd = 32'($urandom_range(0, 7));
         else if (dsel < 8)  wd = $urandom;
         else if (dsel == 8) wd = 32'hFFFF_FFFE;
         else                wd = 32'hFFFF_FFFF;
         if (a == PS_ADDR) wd = 32'($urandom_range(0, 3));
         bus_if.io_bus_s_address = a;
         bus_if.io_bus_s_wr_data = wd;
         if (r < 1) begin
            do_rst();
         end else if (r < 35) begin
            cycle();
         end else if (r < 65) begin
            bus_if.io_bus_s_rd_en = 1'b1;
            cycle();
         end else if (r < 92) begin
            bus_if.io_bus_s_wr_en = 1'b1;
            cycle();
         end else begin
            bus_if.io_bus_s_rd_en = 1'b1;
            bus_if.io_bus_s_wr_en = 1'b1;
            cycle();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
